// File: rtl/gnss_code_nco_epl.sv
// GPS L1 C/A code generator paced by a half-chip code NCO, with early/prompt/late
// replicas from a half-chip delay line and a handshaked whole-chip slew port.
module gnss_code_nco_epl #(
    parameter int NCO_WIDTH  = 32,
    parameter int SPACING_HC = 1,
    parameter int CODE_LEN   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic [4:0]           sv,
    input  logic [NCO_WIDTH-1:0] fcw,
    input  logic                 slew_valid,
    input  logic [9:0]           slew_chips,
    output logic                 slew_ready,
    output logic                 early,
    output logic                 prompt,
    output logic                 late,
    output logic [9:0]           chip,
    output logic                 epoch,
    output logic                 chip_tick
);
    // state    | meaning
    // ST_TRACK | NCO paces the generator; slew requests accepted
    // ST_SLEW  | one generator step per en cycle until the slew count expires

    localparam int DL = 2 * SPACING_HC;
    localparam logic [9:0] CHIP_LAST = 10'(CODE_LEN - 1);

    typedef enum logic {ST_TRACK, ST_SLEW} state_t;

    state_t                 state_q, state_d;
    logic [10:1]            g1_q, g2_q;
    logic [4:0]             sv_q;
    logic                   first_q;
    logic [9:0]             chip_q;
    logic [NCO_WIDTH-1:0]   phase_q;
    logic                   half_q;
    logic [DL-1:0]          dl_q;
    logic [9:0]             slew_cnt_q;
    logic                   epoch_q, chip_tick_q;

    logic                   nco_run, slew_load, slew_step;
    logic [NCO_WIDTH:0]     nco_sum;
    logic                   hc_tick, gen_step;
    logic [10:1]            g1_next, g2_next;
    logic [9:0]             chip_next;
    logic [DL:0]            dl_one;
    logic [DL+1:0]          dl_two;

    // Output tap pair of G2 for each PRN (sv 0 = PRN1).
    function automatic logic g2_tap(input logic [10:1] g, input logic [4:0] prn);
        case (prn)
            5'd0:  g2_tap = g[2] ^ g[6];
            5'd1:  g2_tap = g[3] ^ g[7];
            5'd2:  g2_tap = g[4] ^ g[8];
            5'd3:  g2_tap = g[5] ^ g[9];
            5'd4:  g2_tap = g[1] ^ g[9];
            5'd5:  g2_tap = g[2] ^ g[10];
            5'd6:  g2_tap = g[1] ^ g[8];
            5'd7:  g2_tap = g[2] ^ g[9];
            5'd8:  g2_tap = g[3] ^ g[10];
            5'd9:  g2_tap = g[2] ^ g[3];
            5'd10: g2_tap = g[3] ^ g[4];
            5'd11: g2_tap = g[5] ^ g[6];
            5'd12: g2_tap = g[6] ^ g[7];
            5'd13: g2_tap = g[7] ^ g[8];
            5'd14: g2_tap = g[8] ^ g[9];
            5'd15: g2_tap = g[9] ^ g[10];
            5'd16: g2_tap = g[1] ^ g[4];
            5'd17: g2_tap = g[2] ^ g[5];
            5'd18: g2_tap = g[3] ^ g[6];
            5'd19: g2_tap = g[4] ^ g[7];
            5'd20: g2_tap = g[5] ^ g[8];
            5'd21: g2_tap = g[6] ^ g[9];
            5'd22: g2_tap = g[1] ^ g[3];
            5'd23: g2_tap = g[4] ^ g[6];
            5'd24: g2_tap = g[5] ^ g[7];
            5'd25: g2_tap = g[6] ^ g[8];
            5'd26: g2_tap = g[7] ^ g[9];
            5'd27: g2_tap = g[8] ^ g[10];
            5'd28: g2_tap = g[1] ^ g[6];
            5'd29: g2_tap = g[2] ^ g[7];
            5'd30: g2_tap = g[3] ^ g[8];
            default: g2_tap = g[4] ^ g[9];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        nco_run   = 1'b0;
        slew_load = 1'b0;
        slew_step = 1'b0;
        case (state_q)
            ST_TRACK: begin
                nco_run = en;
                // A zero-chip request is accepted but needs no steps, so ready stays high.
                if (slew_valid && (slew_chips != 10'd0)) begin
                    slew_load = 1'b1;
                    state_d   = ST_SLEW;
                end
            end
            ST_SLEW: begin
                if (en) begin
                    slew_step = 1'b1;
                    if (slew_cnt_q == 10'd1) state_d = ST_TRACK;
                end
            end
            default: state_d = ST_TRACK;
        endcase
        if (clear) state_d = ST_TRACK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_TRACK;
        else     state_q <= state_d;
    end

    assign nco_sum   = {1'b0, phase_q} + {1'b0, fcw};
    assign hc_tick   = nco_run && nco_sum[NCO_WIDTH];
    assign gen_step  = slew_step || (hc_tick && half_q);

    assign g1_next   = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
    assign g2_next   = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    assign chip_next = (chip_q == CHIP_LAST) ? 10'd0 : chip_q + 10'd1;

    assign early     = g1_q[10] ^ g2_tap(g2_q, sv_q);
    // A slew step covers a whole chip, i.e. two half-chip positions of the delay line.
    assign dl_one    = {dl_q, early};
    assign dl_two    = {dl_q, early, early};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_q        <= '1;
            g2_q        <= '1;
            sv_q        <= 5'd0;
            first_q     <= 1'b1;
            chip_q      <= 10'd0;
            phase_q     <= '0;
            half_q      <= 1'b0;
            dl_q        <= '0;
            slew_cnt_q  <= 10'd0;
            epoch_q     <= 1'b0;
            chip_tick_q <= 1'b0;
        end else begin
            epoch_q     <= 1'b0;
            chip_tick_q <= 1'b0;
            first_q     <= 1'b0;
            if (first_q || clear) sv_q <= sv;
            if (clear) begin
                g1_q       <= '1;
                g2_q       <= '1;
                chip_q     <= 10'd0;
                phase_q    <= '0;
                half_q     <= 1'b0;
                dl_q       <= '0;
                slew_cnt_q <= 10'd0;
                epoch_q    <= 1'b1;
            end else begin
                if (slew_load)      slew_cnt_q <= slew_chips;
                else if (slew_step) slew_cnt_q <= slew_cnt_q - 10'd1;

                if (nco_run) begin
                    phase_q <= nco_sum[NCO_WIDTH-1:0];
                    if (hc_tick) half_q <= ~half_q;
                end

                if (slew_step)    dl_q <= dl_two[DL-1:0];
                else if (hc_tick) dl_q <= dl_one[DL-1:0];

                if (gen_step) begin
                    g1_q        <= g1_next;
                    g2_q        <= g2_next;
                    chip_q      <= chip_next;
                    chip_tick_q <= 1'b1;
                    epoch_q     <= (chip_next == 10'd0);
                end
            end
        end
    end

    assign slew_ready = (state_q == ST_TRACK);
    assign prompt     = dl_q[SPACING_HC-1];
    assign late       = dl_q[DL-1];
    assign chip       = chip_q;
    assign epoch      = epoch_q;
    assign chip_tick  = chip_tick_q;

endmodule

// File: tb/tb_gnss_code_nco_epl.sv
// Bench for gnss_code_nco_epl: C/A code table built from the G2-delay formulation,
// lockstep chip/half-chip model, directed scenarios plus randomized stimulus.
module tb_gnss_code_nco_epl;
    logic        clk, rst, en, clear, slew_valid;
    logic [4:0]  sv;
    logic [31:0] fcw;
    logic [9:0]  slew_chips;
    logic        slew_ready, early, prompt, late, epoch, chip_tick;
    logic [9:0]  chip;
    logic        slew_ready2, early2, prompt2, late2, epoch2, chip_tick2;
    logic [9:0]  chip2;

    int n_checks = 0;
    int n_errors = 0;

    gnss_code_nco_epl #(.NCO_WIDTH(32), .SPACING_HC(1), .CODE_LEN(1023)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .sv(sv), .fcw(fcw),
        .slew_valid(slew_valid), .slew_chips(slew_chips), .slew_ready(slew_ready),
        .early(early), .prompt(prompt), .late(late), .chip(chip),
        .epoch(epoch), .chip_tick(chip_tick));

    gnss_code_nco_epl #(.NCO_WIDTH(32), .SPACING_HC(2), .CODE_LEN(1023)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .sv(sv), .fcw(fcw),
        .slew_valid(slew_valid), .slew_chips(slew_chips), .slew_ready(slew_ready2),
        .early(early2), .prompt(prompt2), .late(late2), .chip(chip2),
        .epoch(epoch2), .chip_tick(chip_tick2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: code[p][i] = G1(i) xor G2(i - delay_p), the G2-delay form of the C/A code.
    int g2_delay[32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                         469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};
    bit code_tbl[32][1023];

    function automatic void build_codes();
        bit a[1023];
        bit b[1023];
        for (int i = 0; i < 10; i++) begin
            a[i] = 1'b1;
            b[i] = 1'b1;
        end
        for (int n = 0; n + 10 < 1023; n++) begin
            a[n+10] = a[n+7] ^ a[n];
            b[n+10] = b[n+8] ^ b[n+7] ^ b[n+4] ^ b[n+2] ^ b[n+1] ^ b[n];
        end
        for (int p = 0; p < 32; p++)
            for (int i = 0; i < 1023; i++)
                code_tbl[p][i] = a[i] ^ b[(i - g2_delay[p] + 1023) % 1023];
    endfunction

    longint m_phase;
    bit     m_half, m_first, m_epoch, m_tick;
    int     m_chip, m_sv, m_slew;
    bit     hist[8];   // hist[k] = early value sampled k+1 half-chip ticks ago

    function automatic void model_reset();
        m_phase = 0; m_half = 0; m_first = 1; m_epoch = 0; m_tick = 0;
        m_chip = 0; m_sv = 0; m_slew = 0;
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    endfunction

    function automatic void push_hist(bit v);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
    endfunction

    function automatic void advance_chip();
        m_chip  = (m_chip + 1) % 1023;
        m_tick  = 1;
        m_epoch = (m_chip == 0);
    endfunction

    function automatic void model_edge();
        bit e_old;
        if (rst) begin
            model_reset();
            return;
        end
        m_epoch = 0;
        m_tick  = 0;
        e_old   = code_tbl[m_sv][m_chip];
        if (clear) begin
            m_chip = 0; m_phase = 0; m_half = 0; m_slew = 0; m_epoch = 1;
            for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        end else if (m_slew != 0) begin
            if (en) begin
                push_hist(e_old);
                push_hist(e_old);
                advance_chip();
                m_slew--;
            end
        end else begin
            if (slew_valid && slew_chips != 10'd0) m_slew = int'(slew_chips);
            if (en) begin
                m_phase += longint'(fcw);
                if (m_phase >= 64'h1_0000_0000) begin
                    m_phase -= 64'h1_0000_0000;
                    push_hist(e_old);
                    if (m_half) advance_chip();
                    m_half = !m_half;
                end
            end
        end
        if (clear || m_first) m_sv = int'(sv);
        m_first = 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clear = 1'b0; sv = 5'd0; fcw = 32'd0;
        slew_valid = 1'b0; slew_chips = 10'd0;
        cycle();
        cycle();
        n_checks++;
        if ({chip, early, prompt, late, epoch, chip_tick, slew_ready} !== {10'd0, 6'b100001}) begin
            n_errors++;
            $display("FAIL reset_state got chip=%0d e=%b p=%b l=%b ep=%b ct=%b rdy=%b exp chip=0 e=1 p=0 l=0 ep=0 ct=0 rdy=1",
                     chip, early, prompt, late, epoch, chip_tick, slew_ready);
        end
        n_checks++;
        if ({prompt2, late2, slew_ready2} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_state2 got p=%b l=%b rdy=%b exp 0 0 1", prompt2, late2, slew_ready2);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        bit [9:0] bits;
        bit       eh[8200];
        bit [3:0] got_d, exp_d;
        sv = 5'd0; fcw = 32'h8000_0000; en = 1'b1;
        do_reset();
        bits = '0;
        for (int n = 1; n <= 8190; n++) begin
            cycle();
            eh[n] = early;
            if (n % 4 == 2 && n / 4 < 10) bits[9 - n/4] = early;
            n_checks++;
            if (chip !== 10'((n / 4) % 1023) || epoch !== (n % 4092 == 0) || chip_tick !== (n % 4 == 0)) begin
                n_errors++;
                $display("FAIL nominal_rate cyc=%0d got chip=%0d ep=%b ct=%b exp chip=%0d ep=%b ct=%b",
                         n, chip, epoch, chip_tick, (n / 4) % 1023, n % 4092 == 0, n % 4 == 0);
            end
            if (n >= 10) begin
                got_d = {prompt, late, prompt2, late2};
                exp_d = {eh[n-2], eh[n-4], eh[n-4], eh[n-8]};
                n_checks++;
                if (got_d !== exp_d) begin
                    n_errors++;
                    $display("FAIL epl_spacing cyc=%0d got pl/pl2=%b exp %b", n, got_d, exp_d);
                end
            end
            if (n % 200 == 0) begin
                n_checks++;
                if (early !== code_tbl[0][m_chip]) begin
                    n_errors++;
                    $display("FAIL nominal_code chip=%0d got %b exp %b", m_chip, early, code_tbl[0][m_chip]);
                end
            end
        end
        n_checks++;
        if (bits !== 10'o1440) begin
            n_errors++;
            $display("FAIL prn1_first10 got %o exp 1440", bits);
        end
    endtask

    task automatic test_prn_sweep();
        bit [9:0] first10[3] = '{10'o1620, 10'o1710, 10'o1744};
        bit [9:0] bits;
        int       ep;
        for (int p = 1; p <= 3; p++) begin
            sv = 5'(p); fcw = 32'h8000_0000; en = 1'b1; clear = 1'b1;
            cycle();
            clear = 1'b0;
            bits = '0;
            for (int n = 1; n <= 40; n++) begin
                cycle();
                if (n % 4 == 2) bits[9 - n/4] = early;
            end
            n_checks++;
            if (bits !== first10[p-1]) begin
                n_errors++;
                $display("FAIL prn%0d_first10 got %o exp %o", p + 1, bits, first10[p-1]);
            end
        end
        fcw = 32'd0;
        for (int p = 0; p < 32; p++) begin
            sv = 5'(p); clear = 1'b1;
            cycle();
            clear = 1'b0;
            n_checks++;
            if ({chip, epoch, chip_tick, early} !== {10'd0, 3'b101}) begin
                n_errors++;
                $display("FAIL clear_restart prn%0d got chip=%0d ep=%b ct=%b e=%b exp 0 1 0 1",
                         p + 1, chip, epoch, chip_tick, early);
            end
            slew_valid = 1'b1; slew_chips = 10'd1023;
            cycle();
            slew_valid = 1'b0;
            ep = 0;
            for (int i = 1; i <= 1023; i++) begin
                cycle();
                if (epoch) ep++;
                n_checks++;
                if (early !== code_tbl[p][i % 1023] || chip !== 10'(i % 1023) || slew_ready !== (i == 1023)) begin
                    n_errors++;
                    $display("FAIL prn_period prn%0d step=%0d got e=%b chip=%0d rdy=%b exp e=%b chip=%0d rdy=%b",
                             p + 1, i, early, chip, slew_ready, code_tbl[p][i % 1023], i % 1023, i == 1023);
                end
            end
            n_checks++;
            if (ep != 1) begin
                n_errors++;
                $display("FAIL slew1023_epochs prn%0d got %0d exp 1", p + 1, ep);
            end
        end
    endtask

    task automatic test_slew();
        int low, ep;
        sv = 5'd0; fcw = 32'd0; en = 1'b1;
        do_reset();
        slew_valid = 1'b1; slew_chips = 10'd500;
        cycle();
        slew_valid = 1'b0;
        low = 0; ep = 0;
        for (int n = 0; n < 600 && !slew_ready; n++) begin
            low++;
            if (epoch) ep++;
            cycle();
        end
        n_checks++;
        if (low != 500 || chip !== 10'd500 || ep != 0) begin
            n_errors++;
            $display("FAIL slew500 got low=%0d chip=%0d epochs=%0d exp low=500 chip=500 epochs=0", low, chip, ep);
        end
        slew_valid = 1'b1; slew_chips = 10'd0;
        low = 0;
        for (int n = 0; n < 6; n++) begin
            cycle();
            if (!slew_ready || chip !== 10'd500) low++;
        end
        slew_valid = 1'b0;
        n_checks++;
        if (low != 0) begin
            n_errors++;
            $display("FAIL slew0 got %0d not-ready/moved cycles exp 0", low);
        end
    endtask

    task automatic test_clear_mid();
        bit [9:0] bits;
        bit       hit;
        sv = 5'd0; fcw = 32'h8000_0000; en = 1'b1;
        do_reset();
        hit = 0;
        for (int n = 0; n < 2100 && !hit; n++) begin
            cycle();
            if (chip == 10'd500) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL clear_reach500 got chip=%0d exp 500 within budget", chip);
        end
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        sv = 5'd7;
        n_checks++;
        if ({chip, epoch, early, chip_tick, prompt, late} !== {10'd0, 5'b11000}) begin
            n_errors++;
            $display("FAIL clear_mid got chip=%0d ep=%b e=%b ct=%b p=%b l=%b exp 0 1 1 0 0 0",
                     chip, epoch, early, chip_tick, prompt, late);
        end
        bits = '0;
        for (int n = 1; n <= 40; n++) begin
            cycle();
            if (n % 4 == 2) bits[9 - n/4] = early;
        end
        n_checks++;
        if (bits !== 10'o1440) begin
            n_errors++;
            $display("FAIL sv_no_latch got %o exp 1440", bits);
        end
        sv = 5'd0;
    endtask

    task automatic test_hold();
        int low;
        logic [9:0] c;
        fcw = 32'd0; en = 1'b1;
        do_reset();
        slew_valid = 1'b1; slew_chips = 10'd300;
        cycle();
        slew_valid = 1'b0;
        repeat (100) cycle();
        en = 1'b0;
        repeat (50) cycle();
        n_checks++;
        if (chip !== 10'd100 || slew_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL en_hold got chip=%0d rdy=%b exp 100 0", chip, slew_ready);
        end
        en = 1'b1;
        low = 0;
        for (int n = 0; n < 400 && !slew_ready; n++) begin
            cycle();
            low++;
        end
        n_checks++;
        if (low != 200 || chip !== 10'd300) begin
            n_errors++;
            $display("FAIL en_resume got steps=%0d chip=%0d exp 200 300", low, chip);
        end
        slew_valid = 1'b1; slew_chips = 10'd400;
        cycle();
        slew_valid = 1'b0;
        repeat (50) cycle();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({slew_ready, chip, prompt, late, prompt2, late2} !== {1'b1, 10'd0, 4'b0000}) begin
            n_errors++;
            $display("FAIL rst_mid_slew got rdy=%b chip=%0d p=%b l=%b p2=%b l2=%b exp 1 0 0 0 0 0",
                     slew_ready, chip, prompt, late, prompt2, late2);
        end
        cycle();
        rst = 1'b0;
        fcw = 32'h8000_0000;
        repeat (50) cycle();
        c = chip;
        fcw = 32'd0;
        low = 0;
        repeat (100) begin
            cycle();
            if (chip !== c || chip_tick) low++;
        end
        n_checks++;
        if (low != 0 || c !== 10'd12) begin
            n_errors++;
            $display("FAIL fcw_zero got moved=%0d chip=%0d exp 0 12", low, c);
        end
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        en = 1'b1; fcw = 32'h8000_0000;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 999) < 3);
            en         = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 199) == 0);
            sv         = 5'($urandom_range(0, 31));
            slew_valid = ($urandom_range(0, 29) == 0);
            slew_chips = 10'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: fcw = $urandom;
                    1: fcw = 32'hFFFF_FFFF;
                    2: fcw = 32'd0;
                    3: fcw = 32'h8000_0000;
                    default: fcw = 32'($urandom_range(0, 32'h2000_0000));
                endcase
            end
            cycle();
            got = {slew_ready, early, prompt, late, epoch, chip_tick, chip, prompt2, late2, chip2 == chip, slew_ready2 == slew_ready};
            exp = {m_slew == 0, code_tbl[m_sv][m_chip], hist[0], hist[1], m_epoch, m_tick, 10'(m_chip), hist[1], hist[3], 2'b11};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random cyc=%0d got %b exp %b", n, got, exp);
            end
        end
        rst = 1'b0; clear = 1'b0; slew_valid = 1'b0;
    endtask

    initial begin
        build_codes();
        model_reset();
        test_reset();
        test_nominal();
        test_prn_sweep();
        test_slew();
        test_clear_mid();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gnss_code_nco_epl.md
Name: gnss_code_nco_epl

Overview:
- Parametrised successor to the single-tap L1 C/A code generator.
- Produces a GPS L1 C/A Gold code (any of PRN 1–32) paced by a code NCO rather than a per-cycle enable.
- Provides early, prompt and late replicas with configurable half-chip spacing, plus a handshaked code-phase slew port.
- Feeds one tracking-channel correlator; one instance per channel.

Parameters:
- NCO_WIDTH, 32, code phase accumulator width; carry-out = one half-chip tick.
- SPACING_HC, 1, early-to-prompt and prompt-to-late spacing in half-chips (1..4).
- CODE_LEN, 1023, chips per code period; chip counter wraps at CODE_LEN-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance enable; low freezes NCO, generator, delay line and slew.
- clear  in  1  synchronous restart to chip 0; also latches sv.
- sv  in  5  PRN select, 0 = PRN1 … 31 = PRN32; used only when latched.
- fcw  in  NCO_WIDTH  code NCO frequency word (half-chip rate).
- slew_valid  in  1  slew request.
- slew_chips  in  10  chips to advance, 0..1023.
- slew_ready  out  1  high when idle and able to accept a slew.
- early  out  1  current generator chip (combinational from G1/G2 state and latched sv).
- prompt  out  1  early delayed by SPACING_HC half-chip ticks.
- late  out  1  early delayed by 2*SPACING_HC half-chip ticks.
- chip  out  10  index of the early chip, 0..CODE_LEN-1.
- epoch  out  1  one-cycle pulse when chip becomes 0.
- chip_tick  out  1  one-cycle pulse when the generator advances one chip.

Behaviour:
- Reset values:
  - G1 and G2 = 10'h3FF; sv_q = 0; chip = 0; NCO phase = 0; half flag = 0.
  - Delay line = 0, so prompt = late = 0.
  - epoch = 0; chip_tick = 0; slew_ready = 1.
  - early = 1 (first chip of PRN1).
- sv latching: sv_q loads sv on the first cycle after reset deassertion and on every clear. A change on sv at any other time is ignored.
- NCO, per cycle with en=1 and no slew active:
  - phase <= phase + fcw, truncated to NCO_WIDTH.
  - A carry-out is a half-chip tick: it shifts the delay line by one position (input = early) and toggles the half flag.
  - A tick when half=1 advances the generator one chip.
- Generator step:
  - G1/G2 shift using the standard C/A polynomials (G1 taps 3,10; G2 taps 2,3,6,8,9,10).
  - chip increments and wraps from CODE_LEN-1 to 0.
  - chip_tick=1 in the cycle the new state is visible. epoch=1 in the same cycle if the new chip is 0.
- early output: G1[10] XOR (G2 tap pair for sv_q, per IS-GPS-200 table).
- Slew:
  - Accept when slew_valid && slew_ready. slew_chips=0 is a no-op and ready stays high.
  - Otherwise slew_ready drops the next cycle. The block then performs exactly N generator steps, one per en=1 cycle.
  - Each step shifts the delay line by two positions with early. epoch and chip_tick behave as for NCO steps.
  - The NCO phase and half flag are held during a slew.
  - slew_ready returns high in the cycle after the last step.
- Priority, highest first: rst > clear > slew step > NCO.
- clear, as a synchronous restart:
  - G1 and G2 = all-ones; chip = 0; phase = 0; half = 0; delay line = 0.
  - Any slew in progress is aborted and slew_ready = 1.
  - epoch=1 and chip_tick=0 in the following cycle.
- fcw=0: no ticks, and all outputs hold.
- fcw near full scale: at most one half-chip tick per cycle, so at most one chip per two cycles from the NCO.
- rst mid-slew: immediate return to reset values. The slew is discarded.

Test Plan:
1. Nominal rate: rst pulse, sv=0, fcw=2^31, en=1.
   - One chip per 4 cycles.
   - First 10 early chips = 1100100000 (octal 1440).
   - epoch after 4092 cycles, and periodic thereafter.
2. PRN sweep: for sv=1,2,3, clear and then run.
   - First 10 chips are octal 1620, 1710, 1744.
   - All 32 PRNs match the golden model over a full 1023-chip period.
3. E/P/L spacing: SPACING_HC=1, fcw=2^31.
   - prompt equals early delayed by 2 cycles; late equals early delayed by 4 cycles.
   - Repeat with SPACING_HC=2: delays of 4 and 8 cycles.
4. Slew:
   - From chip 0, slew 500: slew_ready low for 500 cycles, then chip=500, no epoch.
   - Slew 1023: exactly one epoch, chip returns to 0.
   - Slew 0: ready never drops.
5. Clear mid-run: at chip==500, pulse clear.
   - Next cycle: chip=0, epoch=1, early=1.
   - sv change without clear: no effect on code.
6. Hold and reset:
   - en=0 mid-slew freezes both chip and the remaining slew count.
   - rst asserted mid-slew: slew_ready=1, chip=0, prompt=late=0 immediately.
   - fcw=0 for 100 cycles: chip is unchanged.
